div_req_sequencer: RTL and testbench

- Front-end stage for the sequential divider `ha3`: buffers operand pairs, drives its four-phase REQ/ACK handshake, and returns each result on a valid/ready output port.
- Upstream producers push A/D pairs without knowing the divider latency.
- Results come out strictly in push order, with the divide-by-zero flag attached.

---
 rtl/div_req_sequencer.sv | 154 +++++++++++++++
 tb/tb_div_req_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_req_sequencer.sv
// Front end for the sequential divider: queues operand pairs, runs the four-phase
// REQ/ACK exchange with the divider, and hands results out in push order.
module div_req_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_d,
    output logic             div_req,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_d,
    input  logic             div_ack,
    input  logic             div_fdbz,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_dbz,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    logic [2*WIDTH-1:0] mem [DEPTH];

    state_t             state_reg, state_next;
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]      count_reg, count_next;
    logic               in_ready_reg, in_ready_next;
    logic               div_req_reg, div_req_next;
    logic [WIDTH-1:0]   div_a_reg, div_a_next;
    logic [WIDTH-1:0]   div_d_reg, div_d_next;
    logic               out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]   out_q_reg, out_q_next;
    logic [WIDTH-1:0]   out_r_reg, out_r_next;
    logic               out_dbz_reg, out_dbz_next;
    logic               push, pop;

    // in_ready is a registered view of occupancy, so a pop never frees a slot
    // for a push in the same cycle.
    assign push = in_valid && in_ready_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_a, in_d};
        end
    end

    always_comb begin
        state_next     = state_reg;
        div_req_next   = div_req_reg;
        div_a_next     = div_a_reg;
        div_d_next     = div_d_reg;
        out_valid_next = out_valid_reg;
        out_q_next     = out_q_reg;
        out_r_next     = out_r_reg;
        out_dbz_next   = out_dbz_reg;
        pop            = 1'b0;

        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                // A lingering ACK or an unconsumed result both hold off the next issue.
                if ((count_reg != '0) && !out_valid_reg && !div_ack) begin
                    pop                      = 1'b1;
                    state_next               = ISSUE;
                    div_req_next             = 1'b1;
                    {div_a_next, div_d_next} = mem[rd_ptr_reg];
                end
            end
            ISSUE: begin
                if (div_ack) begin
                    state_next     = RELEASE;
                    div_req_next   = 1'b0;
                    out_valid_next = 1'b1;
                    out_q_next     = div_q;
                    out_r_next     = div_r;
                    out_dbz_next   = div_fdbz;
                end
            end
            RELEASE: begin
                if (!div_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        count_next    = count_reg + CW'(push) - CW'(pop);
        in_ready_next = (count_next < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b0;
            div_req_reg   <= 1'b0;
            div_a_reg     <= '0;
            div_d_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_q_reg     <= '0;
            out_r_reg     <= '0;
            out_dbz_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            in_ready_reg  <= in_ready_next;
            div_req_reg   <= div_req_next;
            div_a_reg     <= div_a_next;
            div_d_reg     <= div_d_next;
            out_valid_reg <= out_valid_next;
            out_q_reg     <= out_q_next;
            out_r_reg     <= out_r_next;
            out_dbz_reg   <= out_dbz_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign div_req   = div_req_reg;
    assign div_a     = div_a_reg;
    assign div_d     = div_d_reg;
    assign out_valid = out_valid_reg;
    assign out_q     = out_q_reg;
    assign out_r     = out_r_reg;
    assign out_dbz   = out_dbz_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed and random checks of div_req_sequencer against a queue-based result
// model and a behavioural four-phase divider.
module tb_div_req_sequencer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_d = '0;
    logic             div_req;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_d;
    logic             div_ack = 1'b0;
    logic             div_fdbz = 1'b0;
    logic [WIDTH-1:0] div_q = '0;
    logic [WIDTH-1:0] div_r = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_r;
    logic             out_dbz;
    logic [CW-1:0]    count;

    int   vectors = 0;
    int   miscompares = 0;
    res_t exp_q[$];
    int   lat = 17;
    int   dcnt = 0;
    bit   hold_ack = 1'b0;

    div_req_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_d(in_d),
        .div_req(div_req), .div_a(div_a), .div_d(div_d),
        .div_ack(div_ack), .div_fdbz(div_fdbz), .div_q(div_q), .div_r(div_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz), .count(count)
    );

    initial forever #5 clk = ~clk;

    function automatic res_t ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        res_t x;
        if (d == '0) begin
            x.q = '1; x.r = a; x.dbz = 1'b1;
        end else begin
            x.q = a / d; x.r = a % d; x.dbz = 1'b0;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshakes that complete at this edge, advance, then
    // let the divider model react to what the DUT drives after the edge.
    task automatic tick();
        res_t e;
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_div(in_a, in_d));
            $display("push a=%h d=%h", in_a, in_d);
        end
        if (out_valid && out_ready) begin
            check("sb_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("res_q", 32'(out_q), 32'(e.q));
                check("res_r", 32'(out_r), 32'(e.r));
                check("res_dbz", 32'(out_dbz), 32'(e.dbz));
            end
            $display("result q=%h r=%h dbz=%b", out_q, out_r, out_dbz);
        end
        @(posedge clk);
        #1;
        if (!div_ack) begin
            if (div_req && !hold_ack) begin
                dcnt++;
                if (dcnt >= lat) begin
                    e        = ref_div(div_a, div_d);
                    div_ack  = 1'b1;
                    div_q    = e.q;
                    div_r    = e.r;
                    div_fdbz = e.dbz;
                end
            end
        end else if (!div_req) begin
            div_ack = 1'b0;
            dcnt    = 0;
        end
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(out_valid), 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 0);
        repeat (4) tick();
    endtask

    task automatic push1(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        in_valid = 1'b1; in_a = a; in_d = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int n;

        // Reset state
        repeat (2) tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_count", 32'(count), 0);
        check("rst_div_req", 32'(div_req), 0);
        check("rst_div_a", 32'(div_a), 0);
        check("rst_div_d", 32'(div_d), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_q", 32'(out_q), 0);
        check("rst_out_r", 32'(out_r), 0);
        check("rst_out_dbz", 32'(out_dbz), 0);
        rst_n = 1'b1;
        check("ready_before_edge", 32'(in_ready), 0);
        tick();
        check("ready_after_edge", 32'(in_ready), 1);

        // Single op, 17-cycle divider
        push1(16'h0064, 16'h0007);
        check("lat_count1", 32'(count), 1);
        check("lat_req_low", 32'(div_req), 0);
        tick();
        check("lat_req_high", 32'(div_req), 1);
        check("lat_div_a", 32'(div_a), 'h64);
        check("lat_div_d", 32'(div_d), 'h7);
        check("lat_count0", 32'(count), 0);
        wait_out("single_wait");
        check("single_req_fell", 32'(div_req), 0);
        check("single_q", 32'(out_q), 'h000E);
        check("single_r", 32'(out_r), 'h0002);
        check("single_dbz", 32'(out_dbz), 0);
        tick();
        check("single_consumed", 32'(out_valid), 0);
        drain("single_drain");

        // Divide by zero
        push1(16'h1234, 16'h0000);
        wait_out("dbz_wait");
        check("dbz_flag", 32'(out_dbz), 1);
        check("dbz_q", 32'(out_q), 'hFFFF);
        check("dbz_r", 32'(out_r), 'h1234);
        drain("dbz_drain");

        // Full FIFO with the divider stalled
        hold_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 16'(100 + i * 7); in_d = 16'(3 + i);
            tick();
        end
        check("full_count", 32'(count), 4);
        check("full_ready", 32'(in_ready), 0);
        check("full_req", 32'(div_req), 1);
        in_a = 16'hBEEF; in_d = 16'h0011;
        repeat (3) tick();
        check("full_refused_count", 32'(count), 4);
        check("full_refused_ready", 32'(in_ready), 0);
        hold_ack = 1'b0;
        n = 0;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        check("full_ready_after_pop", 32'(in_ready), 1);
        check("full_count_after_pop", 32'(count), 3);
        tick();
        in_valid = 1'b0;
        drain("full_drain");

        // Backpressure on the result port
        lat = 4;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h8000; in_d = 16'h0002; tick();
        in_a = 16'h0010; in_d = 16'hFFFF; tick();
        in_a = 16'h7FFF; in_d = 16'h7FFF; tick();
        in_valid = 1'b0;
        wait_out("bp_wait");
        repeat (6) tick();
        check("bp_valid_held", 32'(out_valid), 1);
        check("bp_q_stable", 32'(out_q), 'h4000);
        check("bp_r_stable", 32'(out_r), 'h0000);
        check("bp_req_low", 32'(div_req), 0);
        check("bp_count", 32'(count), 2);
        drain("bp_drain");

        // Asynchronous reset in the middle of a handshake
        lat = 30;
        in_valid = 1'b1; in_a = 16'h0100; in_d = 16'h0003; tick();
        in_a = 16'h0200; in_d = 16'h0005; tick();
        in_a = 16'h0300; in_d = 16'h0007; tick();
        in_valid = 1'b0;
        check("mid_req", 32'(div_req), 1);
        check("mid_count", 32'(count), 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(div_req), 0);
        check("arst_valid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_ready", 32'(in_ready), 0);
        exp_q.delete();
        div_ack = 1'b0;
        dcnt = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("arst_ready_back", 32'(in_ready), 1);
        lat = 5;
        push1(16'h00FF, 16'h0010);
        wait_out("arst_fresh_wait");
        check("arst_fresh_q", 32'(out_q), 'h000F);
        check("arst_fresh_r", 32'(out_r), 'h000F);
        drain("arst_drain");

        // Spurious ACK while idle and empty
        div_q = 16'hAAAA; div_r = 16'h5555; div_fdbz = 1'b1; div_ack = 1'b1;
        tick();
        tick();
        check("spur_valid", 32'(out_valid), 0);
        check("spur_req", 32'(div_req), 0);
        check("spur_q_kept", 32'(out_q), 'h000F);
        check("spur_dbz_kept", 32'(out_dbz), 0);
        push1(16'h0007, 16'h0002);
        wait_out("spur_next_wait");
        check("spur_next_q", 32'(out_q), 'h0003);
        check("spur_next_r", 32'(out_r), 'h0001);
        drain("spur_drain");

        // Random traffic, random divider latency and consumer stalls
        for (int i = 0; i < 1500; i++) begin
            if (!div_ack && dcnt == 0) lat = int'($urandom_range(1, 8));
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = 16'($urandom);
            in_d      = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
